// File: rtl/serial_subtractor.sv
// Bit-serial unsigned subtractor, LSB first.
// One full-subtractor cell plus a borrow flop; start/busy/done handshake.
module serial_subtractor #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] diff,
   output logic             borrow_out
);

   localparam int CW = (WIDTH <= 2) ? 1 : $clog2(WIDTH);

   localparam logic [1:0] IDLE  = 2'd0;
   localparam logic [1:0] SHIFT = 2'd1;
   localparam logic [1:0] DONE  = 2'd2;

   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

   logic [1:0]       state;
   logic [WIDTH-1:0] a_sr;
   logic [WIDTH-1:0] b_sr;
   logic             borrow;
   logic [CW-1:0]    cnt;

   logic ai;
   logic bi;
   logic br;
   logic d;
   logic borrow_next;

   always_comb begin
      ai          = a_sr[0];
      bi          = b_sr[0];
      br          = borrow;
      d           = ai ^ bi ^ br;
      borrow_next = (~ai & bi) | (~(ai ^ bi) & br);
   end

   // diff fills from the MSB so after WIDTH shifts bit 0 holds the LSB
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= IDLE;
         a_sr       <= '0;
         b_sr       <= '0;
         borrow     <= 1'b0;
         cnt        <= '0;
         diff       <= '0;
         borrow_out <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (start) begin
                  a_sr       <= a;
                  b_sr       <= b;
                  borrow     <= 1'b0;
                  cnt        <= '0;
                  diff       <= '0;
                  borrow_out <= 1'b0;
                  state      <= SHIFT;
               end
            end
            SHIFT: begin
               a_sr   <= a_sr >> 1;
               b_sr   <= b_sr >> 1;
               diff   <= {d, diff[WIDTH-1:1]};
               borrow <= borrow_next;
               cnt    <= cnt + 1'b1;
               if (cnt == LAST) begin
                  borrow_out <= borrow_next;
                  state      <= DONE;
               end
            end
            DONE: begin
               state <= IDLE;
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

   assign busy = (state == SHIFT);
   assign done = (state == DONE);

endmodule

// File: tb/tb_serial_subtractor.sv
// Directed and exhaustive checks for serial_subtractor.
// WIDTH=8 instance for handshake/timing, WIDTH=4 instance for all pairs.
module tb_serial_subtractor;

   logic       clk;
   logic       rst_n;
   logic       start;
   logic [7:0] a;
   logic [7:0] b;
   logic       busy;
   logic       done;
   logic [7:0] diff;
   logic       borrow_out;

   logic       start4;
   logic [3:0] a4;
   logic [3:0] b4;
   logic       busy4;
   logic       done4;
   logic [3:0] diff4;
   logic       borrow_out4;

   int checks;
   int errors;

   typedef struct {
      logic [7:0] va;
      logic [7:0] vb;
      logic [7:0] ed;
      logic       eb;
   } vec_t;

   vec_t vecs[10];

   serial_subtractor #(.WIDTH(8)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .start     (start),
      .a         (a),
      .b         (b),
      .busy      (busy),
      .done      (done),
      .diff      (diff),
      .borrow_out(borrow_out)
   );

   serial_subtractor #(.WIDTH(4)) dut4 (
      .clk       (clk),
      .rst_n     (rst_n),
      .start     (start4),
      .a         (a4),
      .b         (b4),
      .busy      (busy4),
      .done      (done4),
      .diff      (diff4),
      .borrow_out(borrow_out4)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #300000;
      $display("FAIL watchdog act=timeout req=finish");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s act=%0h req=%0h", nm, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic run8(input logic [7:0] va, input logic [7:0] vb,
                       input logic [7:0] ed, input logic eb,
                       input string nm);
      int nb;
      logic got;
      a = va;
      b = vb;
      start = 1'b1;
      tick();
      start = 1'b0;
      a = ~va;
      b = ~vb;
      nb = 0;
      got = 1'b0;
      for (int i = 0; i < 20 && !got; i++) begin
         if (done) got = 1'b1;
         else begin
            if (busy) nb++;
            tick();
         end
      end
      chk({nm, "_done_seen"}, 32'(got), 32'd1);
      chk({nm, "_busy_cycles"}, nb, 8);
      chk({nm, "_diff"}, 32'(diff), 32'(ed));
      chk({nm, "_borrow"}, 32'(borrow_out), 32'(eb));
      tick();
      chk({nm, "_idle_after"}, {30'd0, busy, done}, 32'd0);
      chk({nm, "_diff_hold"}, 32'(diff), 32'(ed));
   endtask

   task automatic run4(input logic [3:0] va, input logic [3:0] vb);
      logic got;
      logic [3:0] ed;
      logic eb;
      ed = va - vb;
      eb = (va < vb);
      a4 = va;
      b4 = vb;
      start4 = 1'b1;
      tick();
      start4 = 1'b0;
      got = 1'b0;
      for (int i = 0; i < 12 && !got; i++) begin
         if (done4) got = 1'b1;
         else tick();
      end
      if (!got) chk("w4_timeout", 32'd0, 32'd1);
      chk($sformatf("w4_diff_%0h_%0h", va, vb), 32'(diff4), 32'(ed));
      chk($sformatf("w4_borrow_%0h_%0h", va, vb),
          32'(borrow_out4), 32'(eb));
      tick();
   endtask

   initial begin
      int dn;
      int dcyc[$];
      logic got;

      checks = 0;
      errors = 0;

      vecs[0] = '{8'h05, 8'h03, 8'h02, 1'b0};
      vecs[1] = '{8'h03, 8'h05, 8'hFE, 1'b1};
      vecs[2] = '{8'h00, 8'hFF, 8'h01, 1'b1};
      vecs[3] = '{8'hFF, 8'h01, 8'hFE, 1'b0};
      vecs[4] = '{8'h00, 8'h00, 8'h00, 1'b0};
      vecs[5] = '{8'h80, 8'h01, 8'h7F, 1'b0};
      vecs[6] = '{8'hAA, 8'h55, 8'h55, 1'b0};
      vecs[7] = '{8'h55, 8'hAA, 8'hAB, 1'b1};
      vecs[8] = '{8'hFF, 8'hFF, 8'h00, 1'b0};
      vecs[9] = '{8'h01, 8'h02, 8'hFF, 1'b1};

      rst_n  = 1'b0;
      start  = 1'b1;
      a      = 8'h05;
      b      = 8'h03;
      start4 = 1'b1;
      a4     = 4'h5;
      b4     = 4'h3;
      repeat (3) tick();
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_done", 32'(done), 32'd0);
      chk("rst_diff", 32'(diff), 32'd0);
      chk("rst_borrow", 32'(borrow_out), 32'd0);

      start  = 1'b0;
      start4 = 1'b0;
      rst_n  = 1'b1;
      repeat (3) tick();
      chk("idle_busy", 32'(busy), 32'd0);
      chk("idle_done", 32'(done), 32'd0);
      chk("idle_diff", 32'(diff), 32'd0);
      chk("idle_borrow", 32'(borrow_out), 32'd0);

      for (int i = 0; i < 10; i++)
         run8(vecs[i].va, vecs[i].vb, vecs[i].ed, vecs[i].eb,
              $sformatf("vec%0d", i));

      // stray start pulses during SHIFT and during DONE
      a = 8'h37;
      b = 8'h12;
      start = 1'b1;
      tick();
      start = 1'b0;
      a = 8'h00;
      b = 8'hFF;
      dn = 0;
      for (int k = 1; k <= 25; k++) begin
         if (done) dn++;
         start = (k == 2 || k == 8);
         if (done) chk("stray_diff", 32'(diff), 32'h25);
         tick();
      end
      start = 1'b0;
      chk("stray_done_count", dn, 1);
      chk("stray_busy_end", 32'(busy), 32'd0);

      // start held high: back-to-back ops
      a = 8'h10;
      b = 8'h20;
      start = 1'b1;
      for (int k = 0; k < 32; k++) begin
         tick();
         if (done) begin
            dcyc.push_back(k);
            chk("b2b_diff", 32'(diff), 32'hF0);
            chk("b2b_borrow", 32'(borrow_out), 32'd1);
         end
      end
      start = 1'b0;
      chk("b2b_count", dcyc.size(), 3);
      if (dcyc.size() >= 3) begin
         chk("b2b_period1", dcyc[1] - dcyc[0], 10);
         chk("b2b_period2", dcyc[2] - dcyc[1], 10);
      end
      got = 1'b0;
      for (int i = 0; i < 15 && !got; i++) begin
         if (done) got = 1'b1;
         tick();
      end
      chk("b2b_drain", 32'(got), 32'd1);
      tick();

      // reset mid-operation
      a = 8'h80;
      b = 8'h01;
      start = 1'b1;
      tick();
      start = 1'b0;
      repeat (4) tick();
      chk("mid_busy_before", 32'(busy), 32'd1);
      rst_n = 1'b0;
      #1;
      chk("mid_rst_busy", 32'(busy), 32'd0);
      chk("mid_rst_done", 32'(done), 32'd0);
      chk("mid_rst_diff", 32'(diff), 32'd0);
      chk("mid_rst_borrow", 32'(borrow_out), 32'd0);
      dn = 0;
      for (int k = 0; k < 10; k++) begin
         tick();
         if (done) dn++;
      end
      chk("mid_no_done", dn, 0);
      rst_n = 1'b1;
      tick();
      run8(8'h80, 8'h01, 8'h7F, 1'b0, "post_rst");

      for (int i = 0; i < 16; i++)
         for (int j = 0; j < 16; j++)
            run4(4'(i), 4'(j));

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/serial_subtractor.md
# serial_subtractor

Bit-serial unsigned subtractor: computes diff = a − b one bit per clock, LSB first, using a single full-subtractor cell and a registered borrow flip-flop. It is the inverse-operation companion to the team's adder cells. It serves area-constrained datapaths where a WIDTH-bit parallel subtractor is not justified. A start/busy/done handshake sequences operand capture and result delivery.

## Interface

- WIDTH, 8, operand and result width in bits (≥ 2)
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- start  input  1  request; sampled only in IDLE
- a  input  WIDTH  minuend; captured on accepted start
- b  input  WIDTH  subtrahend; captured on accepted start
- busy  output  1  high while in SHIFT
- done  output  1  one-cycle pulse; result valid
- diff  output  WIDTH  (a − b) mod 2^WIDTH
- borrow_out  output  1  final borrow; 1 when a < b

## Operation

- Reset (rst_n low, asynchronous) forces:
  - state = IDLE, busy = 0, done = 0, diff = 0, borrow_out = 0
  - internal shift registers, borrow flip-flop and bit counter cleared
- FSM states: IDLE, SHIFT, DONE.
- IDLE
  - If start = 1: capture a and b into shift registers, clear the borrow flip-flop, clear the counter, clear diff and borrow_out, go to SHIFT.
  - Otherwise hold. diff and borrow_out keep their last values.
- SHIFT
  - Each cycle takes ai = a_sr[0], bi = b_sr[0], br = borrow.
  - d = ai ^ bi ^ br
  - borrow_next = (~ai & bi) | (~(ai ^ bi) & br)
  - diff shifts right with d inserted at the MSB; a_sr and b_sr shift right.
  - Counter increments each cycle. After the WIDTH-th SHIFT cycle (counter = WIDTH−1 when sampled), load borrow_out with borrow_next and go to DONE.
- DONE
  - done = 1 for exactly this cycle, then unconditionally go to IDLE.
- start is ignored in SHIFT and DONE. There is no queuing, and a start held high through DONE is not accepted until the IDLE cycle that follows.
- a and b may change freely after the capture cycle.
- Arithmetic is unsigned modulo 2^WIDTH. borrow_out is the borrow out of the MSB.

## Timing

- Cycle 0: start accepted in IDLE.
- Cycles 1..WIDTH: busy = 1.
- Cycle WIDTH+1: done = 1, busy = 0, diff and borrow_out valid.
- Cycle WIDTH+2: IDLE. Earliest next accept is at cycle WIDTH+2, so throughput is one operation per WIDTH+2 cycles.
- All outputs are registered; there are no combinational paths from inputs to outputs.
- diff and borrow_out are stable from the done cycle until the next accepted start.
- Reset asserted mid-SHIFT aborts immediately: all outputs go to 0 with no done pulse. The first start after deassertion is accepted normally.

## Test plan

- Reset then idle: hold rst_n low, start = 1 → busy, done, diff, borrow_out all 0. Release reset with start = 0 → remains IDLE, outputs 0.
- Basic (WIDTH = 8): a = 0x05, b = 0x03, start pulse → busy high for 8 cycles, done at cycle 9, diff = 0x02, borrow_out = 0.
- Underflow and identities:
  - 0x03 − 0x05 → diff = 0xFE, borrow_out = 1
  - 0x00 − 0xFF → 0x01, 1
  - 0xFF − 0x01 → 0xFE, 0
  - 0x00 − 0x00 → 0x00, 0
- Handshake:
  - Pulse start again at cycles 3 and 9 of an op → ignored, single done pulse.
  - Change a and b after capture → result unchanged.
  - Hold start high continuously → back-to-back ops every 10 cycles.
- Reset mid-operation: assert rst_n low at cycle 4 of 0x80 − 0x01 → outputs 0 immediately, no done. Then run 0x80 − 0x01 → 0x7F, 0.
- Exhaustive (WIDTH = 4): all 256 (a, b) pairs checked against a reference model for diff and borrow_out.
